// File: rtl/apb_dual_master_arbiter.sv
// Two-requester APB arbiter: round-robin grant, registered SETUP/ACCESS sequencer to one peripheral.
// Optional ACCESS wait-state timeout with error response is enabled by defining APB_TIMEOUT_EN.
module apb_dual_master_arbiter #(
  parameter int addr_width     = 32,
  parameter int data_width     = 32,
  parameter int timeout_cycles = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  m0_psel_i,
  input  logic                  m0_penable_i,
  input  logic                  m0_pwrite_i,
  input  logic [addr_width-1:0] m0_paddr_i,
  input  logic [data_width-1:0] m0_pwdata_i,
  output logic [data_width-1:0] m0_prdata_o,
  output logic                  m0_pready_o,
  output logic                  m0_pslverr_o,
  input  logic                  m1_psel_i,
  input  logic                  m1_penable_i,
  input  logic                  m1_pwrite_i,
  input  logic [addr_width-1:0] m1_paddr_i,
  input  logic [data_width-1:0] m1_pwdata_i,
  output logic [data_width-1:0] m1_prdata_o,
  output logic                  m1_pready_o,
  output logic                  m1_pslverr_o,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [addr_width-1:0] PADDR,
  output logic [data_width-1:0] PWDATA,
  input  logic [data_width-1:0] PRDATA,
  input  logic                  PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e state_q;
  logic   grant_q;       // 0 = m0 owns the current transfer, 1 = m1
  logic   last_grant_q;
  logic   grant_d;

  // PENABLE from the requesters carries no arbitration information.
  logic unused_penable;
  assign unused_penable = m0_penable_i ^ m1_penable_i;

  // With both requesting, the master not served last wins; otherwise the sole requester.
  always_comb begin
    grant_d = (m0_psel_i && m1_psel_i) ? ~last_grant_q : m1_psel_i;
  end

`ifdef APB_TIMEOUT_EN
  localparam int cnt_w = $clog2(timeout_cycles) + 1;
  logic [cnt_w-1:0] cnt_q;
  logic             m0_err_q;
  logic             m1_err_q;
  assign m0_pslverr_o = m0_err_q;
  assign m1_pslverr_o = m1_err_q;
`else
  localparam int unused_timeout = timeout_cycles;
  assign m0_pslverr_o = 1'b0;
  assign m1_pslverr_o = 1'b0;
`endif

  // NOTE: all state here is sequential and uses <= so every branch reads pre-edge values.
  always_ff @(posedge PCLK) begin
    // NOTE: synchronous reset clears every output register too, so nothing is acknowledged after it.
    if (!PRESET) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
      m0_prdata_o  <= '0;
      m1_prdata_o  <= '0;
      m0_pready_o  <= 1'b0;
      m1_pready_o  <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q        <= '0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_psel_i || m1_psel_i) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            PADDR        <= grant_d ? m1_paddr_i  : m0_paddr_i;
            PWRITE       <= grant_d ? m1_pwrite_i : m0_pwrite_i;
            PWDATA       <= grant_d ? m1_pwdata_i : m0_pwdata_i;
            PSEL         <= 1'b1;
            state_q      <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state_q <= RESP;
            if (!grant_q) begin
              m0_pready_o <= 1'b1;
              if (!PWRITE) m0_prdata_o <= PRDATA;
`ifdef APB_TIMEOUT_EN
              m0_err_q    <= 1'b0;
`endif
            end else begin
              m1_pready_o <= 1'b1;
              if (!PWRITE) m1_prdata_o <= PRDATA;
`ifdef APB_TIMEOUT_EN
              m1_err_q    <= 1'b0;
`endif
            end
          end
`ifdef APB_TIMEOUT_EN
          // This is the limit-th stalled ACCESS cycle: abort with an error response.
          else if (cnt_q == cnt_w'(timeout_cycles - 1)) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state_q <= RESP;
            if (!grant_q) begin
              m0_pready_o <= 1'b1;
              m0_err_q    <= 1'b1;
              if (!PWRITE) m0_prdata_o <= '0;
            end else begin
              m1_pready_o <= 1'b1;
              m1_err_q    <= 1'b1;
              if (!PWRITE) m1_prdata_o <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          m0_pready_o <= 1'b0;
          m1_pready_o <= 1'b0;
`ifdef APB_TIMEOUT_EN
          m0_err_q    <= 1'b0;
          m1_err_q    <= 1'b0;
`endif
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_dual_master_arbiter.sv
// Self-checking bench for apb_dual_master_arbiter: directed vector table, hand-written corner
// sequences (reset mid-transfer, late request, timeout) and randomized transfers vs a transaction model.
module tb_apb_dual_master_arbiter;

  logic        PCLK, PRESET;
  logic        m0_psel_i, m0_penable_i, m0_pwrite_i;
  logic [31:0] m0_paddr_i, m0_pwdata_i, m0_prdata_o;
  logic        m0_pready_o, m0_pslverr_o;
  logic        m1_psel_i, m1_penable_i, m1_pwrite_i;
  logic [31:0] m1_paddr_i, m1_pwdata_i, m1_prdata_o;
  logic        m1_pready_o, m1_pslverr_o;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY;

  apb_dual_master_arbiter #(.addr_width(32), .data_width(32), .timeout_cycles(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .m0_psel_i(m0_psel_i), .m0_penable_i(m0_penable_i), .m0_pwrite_i(m0_pwrite_i),
    .m0_paddr_i(m0_paddr_i), .m0_pwdata_i(m0_pwdata_i), .m0_prdata_o(m0_prdata_o),
    .m0_pready_o(m0_pready_o), .m0_pslverr_o(m0_pslverr_o),
    .m1_psel_i(m1_psel_i), .m1_penable_i(m1_penable_i), .m1_pwrite_i(m1_pwrite_i),
    .m1_paddr_i(m1_paddr_i), .m1_pwdata_i(m1_pwdata_i), .m1_prdata_o(m1_prdata_o),
    .m1_pready_o(m1_pready_o), .m1_pslverr_o(m1_pslverr_o),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // Transaction-level view of the two requesters and what each should observe.
  logic        pend[2];
  logic        pwr[2];
  logic [31:0] padr[2];
  logic [31:0] pwd[2];
  logic [31:0] prd_m[2];
  int          last;

  typedef struct {
    logic [1:0]  raise;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
    logic [31:0] rdata;
    int          exp_g;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int m);
    return (m == 1) ? m1_pready_o : m0_pready_o;
  endfunction

  function automatic logic [31:0] prd(input int m);
    return (m == 1) ? m1_prdata_o : m0_prdata_o;
  endfunction

  function automatic logic err(input int m);
    return (m == 1) ? m1_pslverr_o : m0_pslverr_o;
  endfunction

  task automatic apply();
    m0_psel_i = pend[0]; m0_penable_i = pend[0]; m0_pwrite_i = pwr[0];
    m0_paddr_i = padr[0]; m0_pwdata_i = pwd[0];
    m1_psel_i = pend[1]; m1_penable_i = pend[1]; m1_pwrite_i = pwr[1];
    m1_paddr_i = padr[1]; m1_pwdata_i = pwd[1];
  endtask

  task automatic raise(input int m, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    pend[m] = 1'b1; pwr[m] = wr; padr[m] = addr; pwd[m] = data;
  endtask

  task automatic raise_rand(input int m);
    raise(m, 1'($urandom_range(1, 0)), $urandom, $urandom);
  endtask

  task automatic tick();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  // Runs one full transfer from an IDLE-cycle negedge and returns at the following IDLE-cycle negedge.
  task automatic do_transfer(input int waits, input logic [31:0] rdata, input int g,
                             input logic [31:0] exp_rd, input logic [1:0] resp_raise);
    int o;
    o = 1 - g;
    apply();
    tick();
    check("setup_psel", PSEL, 1);
    check("setup_penable", PENABLE, 0);
    check("setup_paddr", PADDR, padr[g]);
    check("setup_pwrite", PWRITE, pwr[g]);
    check("setup_pwdata", PWDATA, pwd[g]);
    tick();
    check("access_psel_penable", {PSEL, PENABLE}, 2'b11);
    for (int i = 0; i < waits; i++) begin
      PREADY = 1'b0;
      tick();
      check("wait_no_ready", {rdy(0), rdy(1)}, 0);
      check("wait_psel_penable", {PSEL, PENABLE}, 2'b11);
      check("wait_paddr_stable", PADDR, padr[g]);
    end
    PREADY = 1'b1;
    PRDATA = rdata;
    tick();
    check("ready_granted", rdy(g), 1);
    check("ready_other", rdy(o), 0);
    check("done_psel_penable", {PSEL, PENABLE}, 0);
    check("prdata_granted", prd(g), exp_rd);
    check("prdata_other", prd(o), prd_m[o]);
    check("pslverr_granted", err(g), 0);
    prd_m[g] = exp_rd;
    last     = g;
    PREADY   = 1'b0;
    PRDATA   = $urandom;
    pend[g]  = 1'b0;
    for (int m = 0; m < 2; m++)
      if (resp_raise[m] && !pend[m]) raise_rand(m);
    apply();
    tick();
    check("resp_ready_low", {rdy(0), rdy(1)}, 0);
    check("idle_psel", PSEL, 0);
  endtask

  initial begin
    int g, waits, n;
    logic seen;
    logic [31:0] rdata, exp_rd;

    tbl[0] = '{2'b01, 1'b1, 32'h1A10_0004, 32'h0000_00A5, 0, 32'hDEAD_BEEF, 0, 32'h0};
    tbl[1] = '{2'b10, 1'b0, 32'h1A10_0010, 32'h0,         3, 32'hCAFE_F00D, 1, 32'hCAFE_F00D};
    tbl[2] = '{2'b11, 1'b0, 32'h0000_0100, 32'h0,         0, 32'h1111_1111, 0, 32'h1111_1111};
    tbl[3] = '{2'b00, 1'b0, 32'h0,         32'h0,         1, 32'h2222_2222, 1, 32'h2222_2222};
    tbl[4] = '{2'b01, 1'b1, 32'h0000_0200, 32'h0000_0055, 2, 32'h3333_3333, 0, 32'h1111_1111};

    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; pwr[m] = 1'b0; padr[m] = '0; pwd[m] = '0; prd_m[m] = '0;
    end
    last = 1;
    PRESET = 1'b0;
    PREADY = 1'b0;
    PRDATA = '0;
    apply();
    tick();
    tick();
    check("reset_ctrl", {PSEL, PENABLE, PWRITE}, 0);
    check("reset_addr_data", {PADDR, PWDATA}, 0);
    check("reset_ready", {m0_pready_o, m1_pready_o, m0_pslverr_o, m1_pslverr_o}, 0);
    check("reset_prdata", {m0_prdata_o, m1_prdata_o}, 0);
    PRESET = 1'b1;
    tick();

    // Directed vectors.
    for (int v = 0; v < 5; v++) begin
      if (tbl[v].raise[0]) raise(0, tbl[v].wr, tbl[v].addr, tbl[v].data);
      if (tbl[v].raise[1]) raise(1, tbl[v].wr, tbl[v].addr + 32'd4, tbl[v].data + 32'd1);
      do_transfer(tbl[v].waits, tbl[v].rdata, tbl[v].exp_g, tbl[v].exp_rd, 2'b00);
    end

    // Reset while stalled in ACCESS: nothing acknowledged, arbitration restarts with m0.
    raise(0, 1'b0, 32'h0000_0300, 32'h0);
    apply();
    tick();
    tick();
    PREADY = 1'b0;
    PRESET = 1'b0;
    tick();
    check("rst_mid_ctrl", {PSEL, PENABLE, PWRITE}, 0);
    check("rst_mid_addr", PADDR, 0);
    check("rst_mid_ready", {m0_pready_o, m1_pready_o}, 0);
    check("rst_mid_prdata", {m0_prdata_o, m1_prdata_o}, 0);
    PRESET = 1'b1;
    prd_m[0] = '0; prd_m[1] = '0; last = 1;
    raise(1, 1'b1, 32'h0000_0400, 32'h0000_0077);
    do_transfer(0, 32'h3333_4444, 0, 32'h3333_4444, 2'b00);
    do_transfer(0, 32'h0, 1, prd_m[1], 2'b00);

    // m0 arriving during the RESP cycle of an m1 transfer waits for IDLE.
    raise(1, 1'b0, 32'h0000_0500, 32'h0);
    do_transfer(0, 32'h5555_0000, 1, 32'h5555_0000, 2'b01);
    rdata = 32'h6666_0000;
    do_transfer(0, rdata, 0, pwr[0] ? prd_m[0] : rdata, 2'b00);

    // Peripheral never ready.
    raise(0, 1'b0, 32'h1A10_0020, 32'h0);
    apply();
    tick();
    tick();
    PREADY = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 100) begin
      @(posedge PCLK);
      n++;
      @(negedge PCLK);
      if (m0_pready_o) seen = 1'b1;
    end
`ifdef APB_TIMEOUT_EN
    check("timeout_seen", seen, 1);
    check("timeout_cycles", n, 16);
    check("timeout_pslverr", m0_pslverr_o, 1);
    check("timeout_prdata", m0_prdata_o, 0);
    check("timeout_psel", {PSEL, PENABLE}, 0);
    prd_m[0] = '0;
`else
    check("no_timeout_ready", seen, 0);
    check("no_timeout_psel", {PSEL, PENABLE}, 2'b11);
    PREADY = 1'b1;
    PRDATA = 32'h5A5A_5A5A;
    tick();
    check("late_ready", m0_pready_o, 1);
    check("late_prdata", m0_prdata_o, 32'h5A5A_5A5A);
    prd_m[0] = 32'h5A5A_5A5A;
`endif
    PREADY = 1'b0;
    pend[0] = 1'b0;
    last = 0;
    apply();
    tick();
    check("after_long_ready_low", {m0_pready_o, m1_pready_o}, 0);

    // Randomized traffic against the transaction model.
    for (int t = 0; t < 60; t++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(1, 0) == 1) raise_rand(m);
      if (!pend[0] && !pend[1]) raise_rand(int'($urandom_range(1, 0)));
      g      = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
      rdata  = $urandom;
      exp_rd = pwr[g] ? prd_m[g] : rdata;
      waits  = int'($urandom_range(3, 0));
      do_transfer(waits, rdata, g, exp_rd, 2'($urandom_range(3, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
